// File: rtl/intrusion_event_log_if.sv
`default_nettype none
// ============================================================================
// Module      : intrusion_event_log_if
// Description : Signal bundle between the anti-theft FSM side / log reader
//               and the intrusion event log.
//               master : drives FSM state, ticks, control and read requests
//               slave  : the event log itself (drives read results/status)
// Revision    : 1.0 - initial release
// ============================================================================
interface intrusion_event_log_if #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 8,
    parameter int ST_W  = 3
);
    localparam int c_ADDR_W = $clog2(DEPTH);

    // FSM observation and control
    logic [ST_W-1:0]     EA;
    logic                one_hz_enable;
    logic                enable_siren;
    logic                freeze;
    logic                clear_log;

    // Read port
    logic                rd_req;
    logic [c_ADDR_W-1:0] rd_index;
    logic                rd_valid;
    logic                rd_hit;
    logic [ST_W-1:0]     rd_state;
    logic [ST_W-1:0]     rd_prev;
    logic [TS_W-1:0]     rd_ts;

    // Status
    logic [c_ADDR_W:0]   count;
    logic                overflow;
    logic [3:0]          alarm_count;
    logic [TS_W-1:0]     ts_now;

    modport master (
        output EA, one_hz_enable, enable_siren, freeze, clear_log,
        output rd_req, rd_index,
        input  rd_valid, rd_hit, rd_state, rd_prev, rd_ts,
        input  count, overflow, alarm_count, ts_now
    );

    modport slave (
        input  EA, one_hz_enable, enable_siren, freeze, clear_log,
        input  rd_req, rd_index,
        output rd_valid, rd_hit, rd_state, rd_prev, rd_ts,
        output count, overflow, alarm_count, ts_now
    );
endinterface
`default_nettype wire

// File: rtl/intrusion_event_log.sv
`default_nettype none
// ============================================================================
// Module      : intrusion_event_log
// Description : Timestamped recorder of anti-theft FSM state transitions.
//               Every change of EA (while not frozen) is written into a
//               circular buffer as {new state, previous state, seconds}.
//               The oldest entry is overwritten when full (sticky overflow).
//               Also counts siren rising edges (saturating at 15) and keeps
//               a free-running seconds counter driven by the 1 Hz tick.
// Ports       : clock  - system clock
//               reset  - asynchronous active-high reset
//               bus    - intrusion_event_log_if.slave
//                        (EA/one_hz_enable/enable_siren/freeze/clear_log in,
//                         rd_req/rd_index in, rd_valid/rd_hit/rd_state/
//                         rd_prev/rd_ts out, count/overflow/alarm_count/
//                         ts_now out)
// Revision    : 1.0 - initial release
// ============================================================================
module intrusion_event_log #(
    parameter int DEPTH = 8,    // log entries, power of two, 2..16
    parameter int TS_W  = 8,    // timestamp width in seconds
    parameter int ST_W  = 3     // FSM state code width
) (
    input  wire logic              clock,
    input  wire logic              reset,
    intrusion_event_log_if.slave   bus
);

    localparam int                c_ADDR_W    = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0] c_FULL      = (c_ADDR_W+1)'(DEPTH);
    localparam logic [3:0]        c_ALARM_MAX = 4'd15;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ST_W-1:0]     r_prev_ea;
    logic                r_siren_d;
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W:0]   r_count;
    logic                r_overflow;
    logic [3:0]          r_alarm;
    logic [TS_W-1:0]     r_ts;

    logic                r_rd_valid;
    logic                r_rd_hit;
    logic [ST_W-1:0]     r_rd_state;
    logic [ST_W-1:0]     r_rd_prev;
    logic [TS_W-1:0]     r_rd_ts;

    // Log storage; no reset needed since entries beyond count are never
    // returned.
    logic [ST_W-1:0]     r_mem_state [DEPTH];
    logic [ST_W-1:0]     r_mem_prev  [DEPTH];
    logic [TS_W-1:0]     r_mem_ts    [DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                w_change;
    logic                w_wr_en;
    logic                w_full;
    logic                w_siren_rise;
    logic [c_ADDR_W-1:0] w_rd_addr;
    logic                w_rd_in_range;

    assign w_change      = (bus.EA != r_prev_ea);
    // clear_log wins over a same-cycle transition: nothing is written.
    assign w_wr_en       = w_change && !bus.freeze && !bus.clear_log;
    assign w_full        = (r_count == c_FULL);
    assign w_siren_rise  = bus.enable_siren && !r_siren_d;

    // Newest entry sits just behind the write pointer; power-of-two depth
    // makes the natural wrap of the subtraction the modulo.
    assign w_rd_addr     = r_wr_ptr - c_ADDR_W'(1) - bus.rd_index;
    assign w_rd_in_range = ({1'b0, bus.rd_index} < r_count);

    // ------------------------------------------------------------------
    // Change/edge history: tracks every cycle, even frozen or clearing,
    // so that releasing freeze never produces a stale transition.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev_ea <= '0;
            r_siren_d <= 1'b0;
        end else begin
            r_prev_ea <= bus.EA;
            r_siren_d <= bus.enable_siren;
        end
    end

    // ------------------------------------------------------------------
    // Seconds counter (runs while frozen, wraps naturally)
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ts <= '0;
        end else if (bus.clear_log) begin
            r_ts <= '0;
        end else if (bus.one_hz_enable) begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Write pointer, fill level and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.clear_log) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            if (w_full) begin
                // Writing into a full log replaces the oldest entry.
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + (c_ADDR_W+1)'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Alarm counter: siren rising edges, saturating, counts while frozen
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_alarm <= '0;
        end else if (bus.clear_log) begin
            r_alarm <= '0;
        end else if (w_siren_rise && (r_alarm != c_ALARM_MAX)) begin
            r_alarm <= r_alarm + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Log storage, one write-enable decode per entry
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clock) begin
            if (w_wr_en && (r_wr_ptr == c_ADDR_W'(gi))) begin
                r_mem_state[gi] <= bus.EA;
                r_mem_prev[gi]  <= r_prev_ea;
                r_mem_ts[gi]    <= r_ts;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered read port. Reads see pointer, count and storage as they
    // were before this edge, so a same-cycle write or clear is not visible
    // until the following read.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_hit   <= 1'b0;
            r_rd_state <= '0;
            r_rd_prev  <= '0;
            r_rd_ts    <= '0;
        end else begin
            r_rd_valid <= bus.rd_req;
            if (bus.rd_req) begin
                r_rd_hit <= w_rd_in_range;
                if (w_rd_in_range) begin
                    r_rd_state <= r_mem_state[w_rd_addr];
                    r_rd_prev  <= r_mem_prev[w_rd_addr];
                    r_rd_ts    <= r_mem_ts[w_rd_addr];
                end else begin
                    r_rd_state <= '0;
                    r_rd_prev  <= '0;
                    r_rd_ts    <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.rd_valid    = r_rd_valid;
    assign bus.rd_hit      = r_rd_hit;
    assign bus.rd_state    = r_rd_state;
    assign bus.rd_prev     = r_rd_prev;
    assign bus.rd_ts       = r_rd_ts;
    assign bus.count       = r_count;
    assign bus.overflow    = r_overflow;
    assign bus.alarm_count = r_alarm;
    assign bus.ts_now      = r_ts;

endmodule
`default_nettype wire

// File: tb/tb_intrusion_event_log.sv
`default_nettype none
// ============================================================================
// Module      : tb_intrusion_event_log
// Description : Self-checking bench for intrusion_event_log. Read requests
//               push the expected result (derived from the list of
//               transitions the bench itself drove) into a scoreboard queue;
//               a monitor pops and compares on every rd_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intrusion_event_log;

    localparam int DEPTH = 8;
    localparam int TS_W  = 8;
    localparam int ST_W  = 3;
    localparam int AW    = $clog2(DEPTH);
    localparam int TS_MOD = 1 << TS_W;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    intrusion_event_log_if #(.DEPTH(DEPTH), .TS_W(TS_W), .ST_W(ST_W)) bus ();

    intrusion_event_log #(.DEPTH(DEPTH), .TS_W(TS_W), .ST_W(ST_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic            hit;
        logic [ST_W-1:0] st;
        logic [ST_W-1:0] pv;
        logic [TS_W-1:0] ts;
    } ent_t;

    ent_t sb_q[$];      // expected read results, in request order
    ent_t log_q[$];     // every recorded transition, oldest first
    ent_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;

    int              exp_ts;
    int              exp_alarm;
    bit              exp_ovf;
    logic [ST_W-1:0] cur_ea;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    // Expected read result for an index, from the bench's own history.
    function automatic ent_t hist(input int idx);
        int   n;
        int   avail;
        ent_t e;
        n     = log_q.size();
        avail = (n < DEPTH) ? n : DEPTH;
        e     = '0;
        if (idx < avail) e = log_q[n-1-idx];
        return e;
    endfunction

    // Raise rd_req for the coming edge and record what it must return.
    task automatic rd_push(input int idx);
        bus.rd_index = AW'(idx);
        bus.rd_req   = 1'b1;
        sb_q.push_back(hist(idx));
    endtask

    task automatic read(input int idx);
        rd_push(idx);
        cyc();
        bus.rd_req = 1'b0;
        cyc();
    endtask

    // Drive EA for one cycle, optionally with a tick in the same cycle.
    task automatic trans(input logic [ST_W-1:0] v, input bit tick);
        ent_t e;
        bus.EA            = v;
        bus.one_hz_enable = tick;
        if (!bus.freeze && (v != cur_ea)) begin
            e.hit = 1'b1;
            e.st  = v;
            e.pv  = cur_ea;
            e.ts  = TS_W'(exp_ts);   // value before this cycle's tick
            log_q.push_back(e);
            if (log_q.size() > DEPTH) exp_ovf = 1'b1;
        end
        cur_ea = v;
        if (tick) exp_ts = (exp_ts + 1) % TS_MOD;
        cyc();
        bus.one_hz_enable = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.one_hz_enable = 1'b1;
            exp_ts = (exp_ts + 1) % TS_MOD;
            cyc();
        end
        bus.one_hz_enable = 1'b0;
    endtask

    task automatic siren_edge();
        bus.enable_siren = 1'b1;
        cyc();
        bus.enable_siren = 1'b0;
        cyc();
        if (exp_alarm < 15) exp_alarm++;
    endtask

    task automatic forget_log();
        log_q.delete();
        exp_ts    = 0;
        exp_alarm = 0;
        exp_ovf   = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear_log = 1'b1;
        cyc();
        bus.clear_log = 1'b0;
        forget_log();
    endtask

    task automatic check_status(input string tag);
        int n;
        n = (log_q.size() < DEPTH) ? log_q.size() : DEPTH;
        check({tag, "_count"},    32'(bus.count),       32'(n));
        check({tag, "_overflow"}, 32'(bus.overflow),    32'(exp_ovf));
        check({tag, "_alarm"},    32'(bus.alarm_count), 32'(exp_alarm));
        check({tag, "_ts_now"},   32'(bus.ts_now),      32'(exp_ts));
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        if (!reset && bus.rd_valid) begin
            if (sb_q.size() == 0) begin
                check("rd_spurious_valid", 32'(1), 32'(0));
            end else begin
                mon_e = sb_q.pop_front();
                check("rd_hit",   32'(bus.rd_hit),   32'(mon_e.hit));
                check("rd_state", 32'(bus.rd_state), 32'(mon_e.st));
                check("rd_prev",  32'(bus.rd_prev),  32'(mon_e.pv));
                check("rd_ts",    32'(bus.rd_ts),    32'(mon_e.ts));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset             = 1'b1;
        bus.EA            = '0;
        bus.one_hz_enable = 1'b0;
        bus.enable_siren  = 1'b0;
        bus.freeze        = 1'b0;
        bus.clear_log     = 1'b0;
        bus.rd_req        = 1'b0;
        bus.rd_index      = '0;
        cur_ea            = '0;
        forget_log();

        repeat (3) cyc();
        check("rst_rd_valid", 32'(bus.rd_valid), 32'(0));
        check("rst_rd_hit",   32'(bus.rd_hit),   32'(0));
        check("rst_rd_state", 32'(bus.rd_state), 32'(0));
        check("rst_rd_prev",  32'(bus.rd_prev),  32'(0));
        check("rst_rd_ts",    32'(bus.rd_ts),    32'(0));
        check_status("rst");
        reset = 1'b0;
        cyc();

        // First transition at ts_now = 5
        ticks(5);
        check("t1_ts_now", 32'(bus.ts_now), 32'(5));
        trans(3'd1, 1'b0);
        check("t1_count", 32'(bus.count), 32'(1));
        read(0);
        read(1);                        // beyond count: miss

        // Frozen EA changes 1->2->3 leave the log alone, even on unfreeze
        bus.freeze = 1'b1;
        trans(3'd2, 1'b0);
        trans(3'd3, 1'b1);              // timer keeps running while frozen
        siren_edge();                   // alarm still counts while frozen
        bus.freeze = 1'b0;
        cyc();
        cyc();
        check_status("frz");
        read(0);

        // Read in the same cycle as a transition sees the older newest
        rd_push(0);
        trans(3'd4, 1'b0);
        rd_push(0);                     // back-to-back: now sees the new one
        cyc();
        bus.rd_req = 1'b0;
        cyc();
        read(3);
        check_status("rbw");

        // Ten transitions into an 8-deep log
        do_clear();
        check_status("clr1");
        for (int i = 0; i < 10; i++) begin
            trans(cur_ea + 3'd1, (i % 3) == 0);
            if (i == 4) siren_edge();
        end
        check_status("full");
        check("full_overflow_set", 32'(bus.overflow), 32'(1));
        rd_push(7);
        cyc();
        rd_push(0);
        cyc();
        rd_push(3);
        cyc();
        bus.rd_req = 1'b0;
        cyc();

        // Clear wins over same-cycle transition, tick and siren edge
        bus.EA            = cur_ea + 3'd2;
        cur_ea            = cur_ea + 3'd2;
        bus.one_hz_enable = 1'b1;
        bus.enable_siren  = 1'b1;
        bus.clear_log     = 1'b1;
        cyc();
        bus.one_hz_enable = 1'b0;
        bus.enable_siren  = 1'b0;
        bus.clear_log     = 1'b0;
        forget_log();
        cyc();
        check_status("clr2");
        read(0);

        // Alarm saturation and timestamp wrap
        for (int i = 0; i < 17; i++) siren_edge();
        check("sat_alarm", 32'(bus.alarm_count), 32'(15));
        ticks(255);
        check("wrap_ts_255", 32'(bus.ts_now), 32'(255));
        ticks(1);
        check("wrap_ts_0", 32'(bus.ts_now), 32'(0));
        trans(cur_ea + 3'd1, 1'b0);
        check_status("wrap");
        read(0);

        // Asynchronous reset drops a pending read result
        bus.rd_index = '0;
        bus.rd_req   = 1'b1;
        @(posedge clock);
        #1;
        bus.rd_req = 1'b0;
        check("arst_pre_valid", 32'(bus.rd_valid), 32'(1));
        reset = 1'b1;
        #1;
        check("arst_valid_dropped", 32'(bus.rd_valid), 32'(0));
        check("arst_count",         32'(bus.count),    32'(0));
        bus.EA = '0;
        cur_ea = '0;
        forget_log();
        cyc();
        reset = 1'b0;
        cyc();
        check_status("post_rst");

        repeat (3) cyc();
        check("sb_drained", 32'(sb_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/intrusion_event_log.md
Name: intrusion_event_log

Overview:
Event recorder sitting directly downstream of the anti-theft FSM. It watches the FSM state code EA and the siren enable, and timestamps every state transition in seconds using the one_hz_enable tick. Each transition is stored in a circular buffer that overwrites the oldest entry when full. A registered read port feeds the display driver and other debug consumers, so the owner can browse recent intrusion history.

Parameters:
DEPTH, 8, number of log entries; power of two, 2..16
TS_W, 8, timestamp width in seconds
ST_W, 3, FSM state code width (matches EA)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
EA  input  ST_W  current FSM state code
one_hz_enable  input  1  single-cycle 1 Hz tick from timer
enable_siren  input  1  siren request from FSM
freeze  input  1  suspend logging (held high during reprogram)
clear_log  input  1  synchronous clear of log, counters and timestamp
rd_req  input  1  read strobe, single cycle
rd_index  input  $clog2(DEPTH)  entry to read; 0 = newest
rd_valid  output  1  one-cycle pulse; read result is valid
rd_hit  output  1  with rd_valid: 1 = rd_index < count
rd_state  output  ST_W  new state of the entry
rd_prev  output  ST_W  previous state of the entry
rd_ts  output  TS_W  timestamp of the entry
count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH
overflow  output  1  sticky; set when an entry was overwritten
alarm_count  output  4  rising edges of enable_siren, saturating at 15
ts_now  output  TS_W  running seconds counter

Behaviour:
- Reset (asynchronous):
  - All outputs go to 0: rd_valid, rd_hit, rd_state, rd_prev, rd_ts, count, overflow, alarm_count, ts_now.
  - prev_EA goes to 0, and wr_ptr goes to 0.
  - Buffer contents are don't-care; they are unreachable while count=0.
- Timestamp:
  - ts_now increments by 1 on each clock where one_hz_enable=1.
  - Wraps from 2^TS_W-1 to 0.
  - Keeps counting while freeze=1.
- Change detect:
  - prev_EA is registered every clock, including while frozen.
  - A transition is a cycle where EA != prev_EA.
  - Each transition writes one entry {state=EA, prev=prev_EA, ts=ts_now}.
  - The timestamp is the ts_now value before any increment in that same cycle.
  - Latency: the entry and the updated count are visible from the next clock edge.
- freeze=1: no writes. prev_EA still tracks EA, so no entry appears when freeze falls.
- Write pointer: on each write, wr_ptr advances modulo DEPTH.
- Full buffer:
  - count increments on each write, saturating at DEPTH.
  - A write while count=DEPTH overwrites the oldest entry and sets overflow.
  - overflow stays set until clear_log or reset.
- alarm_count:
  - Increments on each 0->1 edge of enable_siren; edge detect uses a registered copy of enable_siren.
  - Counts even while frozen.
  - Saturates at 15 and does not wrap.
- clear_log (synchronous):
  - Next cycle: count=0, overflow=0, alarm_count=0, ts_now=0, wr_ptr=0.
  - clear_log has priority over a same-cycle transition, tick or siren edge; none of them are recorded.
  - prev_EA still updates to EA.
- Read handshake:
  - rd_req sampled high produces rd_valid=1 for exactly one cycle on the next clock.
  - Entry address = (wr_ptr - 1 - rd_index) mod DEPTH.
  - The read uses buffer and count values from before any same-cycle write or clear (read-before-write).
  - If rd_index >= count: rd_hit=0 and rd_state, rd_prev, rd_ts are 0.
  - Back-to-back rd_req every cycle is legal; each produces one result.
  - rd_state, rd_prev and rd_ts hold their values between reads.
- Asynchronous reset mid-read: the pending rd_valid is dropped.

Test Plan:
1. Reset, then EA 0->1 at ts_now=5 -> next cycle count=1; rd_req with index 0 -> rd_valid=1, rd_hit=1, state=1, prev=0, ts=5.
2. Ten transitions with DEPTH=8 -> count=8, overflow=1; index 7 returns the 3rd transition; index 0 returns the 10th.
3. freeze=1 across EA changes 1->2->3, then freeze=0 -> no new entries, count unchanged, and no entry on unfreeze.
4. Same-cycle EA change, one_hz_enable and clear_log -> count=0, ts_now=0, overflow=0; following read of index 0 -> rd_hit=0, data 0.
5. 17 rising edges of enable_siren -> alarm_count=15; 256 ticks from ts_now=0 -> ts_now wraps to 0.
6. rd_req with index 0 in the same cycle as a transition -> returns the previous newest entry; a repeated read the next cycle returns the new entry.
